// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetcher state encoding, word-instruction test,
// NOP opcode and the prefetch buffer entry width.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetchState_t;

    localparam logic [7:0] NOP_OPCODE  = 8'h00;

    // Buffer entry: {odd-start tag, 15-bit word address, 16-bit word}
    localparam int         ENTRY_WIDTH = 32;

    // Any of the top three bits set marks a push/jump/call word instruction
    function automatic logic isWordInsn(input logic [15:0] word);
        return word[15:13] != 3'b000;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO with flush. A write is
// accepted while full when a pop happens in the same cycle.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wrEn,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic             i_rdEn,
    output logic [WIDTH-1:0] o_rdData,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doWrite;
    logic             w_doRead;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_rdData  = r_mem[r_rdPtr];
    assign w_doRead  = i_rdEn && !o_empty;
    assign w_doWrite = i_wrEn && (!o_full || w_doRead);

    // Pointer and occupancy update; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doWrite) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doRead)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_doWrite && !w_doRead)
                r_count <= r_count + 1'b1;
            else if (!w_doWrite && w_doRead)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage array; contents are meaningless until pointed at by a write
    always_ff @(posedge clk) begin
        if (w_doWrite) r_mem[r_wrPtr] <= i_wrData;
    end

endmodule

// File: rtl/insn_prefetch.sv
// Instruction prefetcher: fetches 16-bit words into a small buffer and hands
// word instructions or single byte opcodes to the decoder.
// Optional feature macro PREFETCH_NOP_SKIP_EN: when defined, byte opcode 0x00
// is consumed silently instead of being presented.
module insn_prefetch
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [15:0] insn_word,
    output logic        insn_is_word,
    output logic [7:0]  insn_op,
    output logic [15:0] insn_ip,
    input  logic        redir_valid,
    input  logic [15:0] redir_ip
);

    fetchState_t r_state;
    fetchState_t w_nextState;
    logic [14:0] r_fetchPtr;
    logic [14:0] r_memAddr;
    logic        r_oddStart;
    logic        r_lowHalf;

    logic        w_full;
    logic        w_empty;
    logic        w_wrEn;
    logic [31:0] w_head;
    logic [15:0] w_headWord;
    logic [14:0] w_headAddr;
    logic        w_headOdd;
    logic        w_isWord;
    logic        w_lowSel;
    logic [7:0]  w_op;
    logic        w_isNop;
    logic        w_present;
    logic        w_consume;
    logic        w_pop;

    assign w_wrEn     = (r_state == REQ) && mem_ack && !redir_valid;
    assign w_headWord = w_head[15:0];
    assign w_headAddr = w_head[30:16];
    assign w_headOdd  = w_head[31];
    assign w_isWord   = isWordInsn(w_headWord);
    assign w_lowSel   = r_lowHalf || w_headOdd;
    assign w_op       = w_lowSel ? w_headWord[7:0] : w_headWord[15:8];

`ifdef PREFETCH_NOP_SKIP_EN
    assign w_isNop    = !w_isWord && (w_op == NOP_OPCODE);
`else
    assign w_isNop    = 1'b0;
`endif

    assign w_present  = !rst && !w_empty && !w_isNop;
    assign w_consume  = !w_empty && (w_isNop || (w_present && insn_ready));
    assign w_pop      = w_consume && (w_isWord || w_lowSel);

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (redir_valid),
        .i_wrEn   (w_wrEn),
        .i_wrData ({r_oddStart, r_memAddr, mem_data}),
        .i_rdEn   (w_pop),
        .o_rdData (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Fetcher state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Fetcher next state; a redirect in IDLE waits a cycle so the new pointer is latched
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (!redir_valid && !w_full) w_nextState = REQ;
            REQ: begin
                if (mem_ack)          w_nextState = IDLE;
                else if (redir_valid) w_nextState = DROP;
            end
            DROP: if (mem_ack) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Fetch pointer, held read address and odd-start flag for the first word after a redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPtr <= '0;
            r_memAddr  <= '0;
            r_oddStart <= 1'b0;
        end else begin
            if (redir_valid) begin
                r_fetchPtr <= redir_ip[15:1];
                r_oddStart <= redir_ip[0];
            end else if (w_wrEn) begin
                r_fetchPtr <= r_fetchPtr + 15'd1;
                r_oddStart <= 1'b0;
            end
            if (r_state == IDLE && w_nextState == REQ)
                r_memAddr <= r_fetchPtr;
        end
    end

    // Tracks that the high byte of the head entry has already been consumed
    always_ff @(posedge clk) begin
        if (rst || redir_valid)  r_lowHalf <= 1'b0;
        else if (w_pop)          r_lowHalf <= 1'b0;
        else if (w_consume)      r_lowHalf <= 1'b1;
    end

    // Memory request outputs, forced quiet while in reset
    always_comb begin
        mem_rd   = !rst && (r_state != IDLE);
        mem_addr = rst ? 15'd0 : r_memAddr;
    end

    // Decoder-facing outputs, zero whenever nothing is presented
    always_comb begin
        insn_valid   = 1'b0;
        insn_word    = '0;
        insn_op      = '0;
        insn_ip      = '0;
        insn_is_word = 1'b0;
        if (w_present) begin
            insn_valid   = 1'b1;
            insn_word    = w_headWord;
            insn_op      = w_op;
            insn_is_word = w_isWord;
            insn_ip      = {w_headAddr, !w_isWord && w_lowSel};
        end
    end

endmodule

// File: tb/tb_insn_prefetch.sv
// Scoreboard bench for insn_prefetch: a memory responder with adjustable
// latency, a reference stream model filling an expectation queue on each
// restart, and a monitor comparing every accepted instruction.
module tb_insn_prefetch;

    localparam int DEPTH = 4;

`ifdef PREFETCH_NOP_SKIP_EN
    localparam bit NopSkip = 1'b1;
`else
    localparam bit NopSkip = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic        insn_valid;
    logic        insn_ready;
    logic [15:0] insn_word;
    logic        insn_is_word;
    logic [7:0]  insn_op;
    logic [15:0] insn_ip;
    logic        redir_valid;
    logic [15:0] redir_ip;

    typedef struct packed {
        logic        isWord;
        logic [15:0] value;
        logic [15:0] ip;
    } expT;

    expT         expQ[$];
    logic [15:0] memArr [int];
    int          compareCount = 0;
    int          mismatchCount = 0;
    int          memLatency = 1;
    int          ackCount = 0;

    insn_prefetch #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ack      (mem_ack),
        .insn_valid   (insn_valid),
        .insn_ready   (insn_ready),
        .insn_word    (insn_word),
        .insn_is_word (insn_is_word),
        .insn_op      (insn_op),
        .insn_ip      (insn_ip),
        .redir_valid  (redir_valid),
        .redir_ip     (redir_ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: explicit words, otherwise a word instruction tagged by its address
    function automatic logic [15:0] memRead(input logic [14:0] a);
        if (memArr.exists(int'(a))) return memArr[int'(a)];
        return {3'b001, a[12:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: decoder-visible stream starting at byte address startIp
    task automatic pushExpected(input logic [15:0] startIp, input int n);
        logic [14:0] a;
        logic        low;
        logic [15:0] w;
        logic [7:0]  op;
        expT         e;
        int          pushed;
        a = startIp[15:1];
        low = startIp[0];
        pushed = 0;
        while (pushed < n) begin
            w = memRead(a);
            if (w[15:13] != 3'b000) begin
                e.isWord = 1'b1;
                e.value  = w;
                e.ip     = {a, 1'b0};
                expQ.push_back(e);
                pushed++;
            end else begin
                for (int h = (low ? 1 : 0); h < 2; h++) begin
                    op = (h == 0) ? w[15:8] : w[7:0];
                    if (!(NopSkip && op == 8'h00)) begin
                        e.isWord = 1'b0;
                        e.value  = {8'h00, op};
                        e.ip     = {a, h[0]};
                        expQ.push_back(e);
                        pushed++;
                    end
                end
            end
            a = a + 15'd1;
            low = 1'b0;
        end
    endtask

    // Redirect for one cycle and restart the expectation stream at the new address
    task automatic applyStimulus(input logic [15:0] ip, input int n);
        redir_valid = 1'b1;
        redir_ip    = ip;
        tick();
        redir_valid = 1'b0;
        checkOutput("valid after redirect", insn_valid, 1'b0);
        expQ.delete();
        pushExpected(ip, n);
    endtask

    task automatic waitRdRise();
        for (int i = 0; i < 100 && mem_rd; i++) tick();
        for (int i = 0; i < 100 && !mem_rd; i++) tick();
        checkOutput("rd rise", mem_rd, 1'b1);
    endtask

    task automatic waitReqAddr(input string tag, input logic [14:0] expAddr);
        waitRdRise();
        checkOutput(tag, mem_addr, expAddr);
    endtask

    task automatic waitQueueEmpty(input string tag);
        for (int i = 0; i < 300 && expQ.size() > 0; i++) tick();
        checkOutput(tag, expQ.size(), 0);
    endtask

    // Memory responder: acknowledges after memLatency cycles and checks the address holds
    initial begin
        logic [14:0] reqAddr;
        int          waitCnt;
        bit          pending;
        mem_ack = 1'b0;
        mem_data = '0;
        pending = 0;
        reqAddr = '0;
        waitCnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack = 1'b0;
                pending = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_rd) begin
                if (!pending) begin
                    pending = 1;
                    reqAddr = mem_addr;
                    waitCnt = 0;
                end else begin
                    checkOutput("addr stable", mem_addr, reqAddr);
                end
                waitCnt++;
                if (waitCnt >= memLatency) begin
                    mem_ack  = 1'b1;
                    mem_data = memRead(reqAddr);
                    pending  = 0;
                    ackCount++;
                end
            end
        end
    end

    // Monitor: every accepted transfer is checked against the scoreboard head
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (!rst && insn_valid && insn_ready && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("is_word", insn_is_word, e.isWord);
                checkOutput("ip", insn_ip, e.ip);
                if (e.isWord) checkOutput("word", insn_word, e.value);
                else          checkOutput("op", insn_op, e.value[7:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        insn_ready = 1'b0;
        redir_valid = 1'b0;
        redir_ip = '0;
        memArr[0]      = 16'h8005;
        memArr[1]      = 16'h0A0B;
        memArr[9]      = 16'h0C0D;
        memArr[16'h20] = 16'h1A2B;
        memArr[16'h28] = 16'h0F0E;
        memArr[16'h30] = 16'h0100;
        memArr[16'h80] = 16'h1234;
        memArr[16'h7FFF] = 16'h2222;

        // Reset values
        tick(); tick(); tick();
        checkOutput("rst mem_rd", mem_rd, 1'b0);
        checkOutput("rst mem_addr", mem_addr, 15'd0);
        checkOutput("rst insn_valid", insn_valid, 1'b0);
        checkOutput("rst insn_word", insn_word, 16'h0);
        checkOutput("rst insn_op", insn_op, 8'h0);
        checkOutput("rst insn_ip", insn_ip, 16'h0);
        checkOutput("rst insn_is_word", insn_is_word, 1'b0);

        // Start from address 0, first word presented one cycle after its ack
        memLatency = 2;
        insn_ready = 1'b1;
        pushExpected(16'h0000, 4);
        rst = 1'b0;
        for (int i = 0; i < 20 && !mem_rd; i++) tick();
        checkOutput("first req addr", mem_addr, 15'd0);
        checkOutput("valid before ack", insn_valid, 1'b0);
        for (int i = 0; i < 20 && !mem_ack; i++) tick();
        checkOutput("valid after ack", insn_valid, 1'b1);
        waitQueueEmpty("drain start");

        // Odd redirect onto a byte word, then onto a word instruction
        applyStimulus(16'h0013, 4);
        waitQueueEmpty("drain odd byte");
        applyStimulus(16'h0015, 3);
        waitQueueEmpty("drain odd word");

        // Redirect while a read is outstanding; stale data must be dropped
        memLatency = 4;
        waitRdRise();
        applyStimulus(16'h0040, 4);
        waitReqAddr("addr after drop", 15'h0020);
        waitQueueEmpty("drain drop");

        // Redirect in the same cycle as the ack
        memLatency = 1;
        waitRdRise();
        applyStimulus(16'h0050, 4);
        waitReqAddr("addr after ack redirect", 15'h0028);
        waitQueueEmpty("drain ack redirect");

        // Decoder stalled: buffer fills to DEPTH and outputs hold
        insn_ready = 1'b0;
        for (int i = 0; i < 100 && mem_rd; i++) tick();
        checkOutput("idle before stall", mem_rd, 1'b0);
        applyStimulus(16'h0100, 6);
        ackCount = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c >= 16) begin
                checkOutput("stall valid", insn_valid, 1'b1);
                checkOutput("stall ip", insn_ip, 16'h0100);
                checkOutput("stall op", insn_op, 8'h12);
            end
        end
        checkOutput("stall fill", ackCount, DEPTH);
        checkOutput("stall rd", mem_rd, 1'b0);
        insn_ready = 1'b1;
        waitQueueEmpty("drain stall");

        // Fetch pointer wraps from 0x7FFF to 0
        memLatency = 2;
        applyStimulus(16'hFFFE, 4);
        waitReqAddr("addr top", 15'h7FFF);
        waitReqAddr("addr wrap", 15'h0000);
        waitQueueEmpty("drain wrap");

        // Byte word containing a zero opcode
        applyStimulus(16'h0060, 3);
        waitQueueEmpty("drain nop");

        // Reset during an outstanding read
        memLatency = 3;
        waitRdRise();
        rst = 1'b1;
        tick();
        checkOutput("rst mid mem_rd", mem_rd, 1'b0);
        checkOutput("rst mid mem_addr", mem_addr, 15'd0);
        checkOutput("rst mid valid", insn_valid, 1'b0);
        expQ.delete();
        tick();
        pushExpected(16'h0000, 3);
        rst = 1'b0;
        waitReqAddr("addr after reset", 15'h0000);
        waitQueueEmpty("drain reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
